irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Interrupt controller between the peripheral sources (timer IRQ0/IRQ1, external interrupt, spare device lines) and CP0 in the 5-stage pipeline.
- Synchronises and latches source requests, applies per-source mask and edge/level mode, and picks the highest-priority pending source.
- Presents one vectored request to CP0 with a req/ack handshake, and holds it in service until CP0 signals eret.
- Software-visible registers are reached through the bridge using the same addr/WE/Din/Dout word interface as other bridge devices.

Parameters:
- NSRC, 6, number of interrupt sources (1..8); index 0 is highest priority.
- BASE_ADDR, 32'h0000_7F20, byte address of the 16-byte register window.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- src  input  NSRC  raw interrupt lines, asynchronous to clk.
- we  input  1  bridge write strobe, already gated by the pipeline flush.
- addr  input  32  bridge byte address.
- wdata  input  32  bridge write data.
- rdata  output  32  read data, combinational from addr.
- irq_req  output  1  interrupt request to CP0 (registered).
- irq_vec  output  3  source index of the request; stable while irq_req=1.
- irq_ack  input  1  one-cycle pulse from CP0 when it takes the exception.
- eret  input  1  one-cycle pulse when eret reaches the M stage.

Behaviour:
- Reset (reset=0, async): sync flops, PEND, MASK, EDGE, CUR, state=IDLE, irq_req=0, irq_vec=0 all cleared. A reset asserted mid-handshake aborts it with no pulse.
- Register decode applies when addr[31:4]==BASE_ADDR[31:4]. Offset is addr[3:2]; addr[1:0] is ignored. Addresses outside the window read 0, and writes there have no effect.
  - 0x0 PEND: read-only; writing 1 to a bit clears that bit (edge-mode sources only).
  - 0x4 MASK: read/write; 1 enables the source.
  - 0x8 EDGE: read/write; 1 selects rising-edge mode, 0 selects level mode.
  - 0xC CUR: read-only; bit31 = in-service, bits[2:0] = index.
  - Bits at or above NSRC read 0.
- Source synchronisation: each src bit passes through a 2-flop synchroniser (s2); edge detect compares s2 with the previous s2 value (s3).
- Pending update:
  - Edge mode: PEND[i] is set on a rising edge of s2.
  - Level mode: PEND[i] = s2.
  - If a set and a W1C hit the same cycle, the set wins.
- Latency: src sampled high at edge N, PEND set at edge N+2, irq_req=1 after edge N+3, provided the source is enabled and the state is IDLE.
- Enabled set: en = PEND & MASK. The winner is the lowest index in en.
- FSM transitions:
  - IDLE: if en!=0, go to REQ and register irq_vec=winner, irq_req=1.
  - REQ: irq_req=1 and irq_vec is held frozen.
    - On irq_ack: go to SERVICE, irq_req=0, CUR={1,irq_vec}, and clear PEND[irq_vec] if that source is edge mode.
    - Without ack, if en[irq_vec] becomes 0 (masked or W1C): withdraw to IDLE with irq_req=0.
    - Ack and withdraw in the same cycle: ack wins.
    - A higher-priority source arriving during REQ does not re-vector.
  - SERVICE: irq_req=0; no nesting. On eret: go to IDLE and clear CUR.valid. New requests are evaluated from the next cycle.
- irq_ack seen in IDLE or SERVICE is ignored. eret seen in IDLE or REQ is ignored.
- A level source still high after eret re-requests 1 cycle later (IDLE, then REQ).
- Register write and FSM update in the same cycle: the write takes effect first for the en computed in the next cycle.

Decomposition:
- Package irq_ctrl_pkg holds:
  - register offsets (OFF_PEND, OFF_MASK, OFF_EDGE, OFF_CUR);
  - 2-bit state encoding (ST_IDLE, ST_REQ, ST_SERVICE);
  - a lowest-index priority-encode function.
- One sub-module, irq_sync_edge: per-source 2-flop synchroniser plus rise detector, instantiated NSRC times via generate. Outputs s2 and rise.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC -> all return 0; irq_req=0.
- Write MASK=0x3F and EDGE=0x01, pulse src[0] for 1 cycle -> irq_req=1 three cycles after sample, irq_vec=0. Ack -> PEND=0, CUR=0x8000_0000. eret -> IDLE.
- MASK=0x3F, level src[2] and src[4] high together -> irq_vec=2. Ack, eret with src[2] still high -> re-request with irq_vec=2. Drop src[2], ack, eret -> next request irq_vec=4.
- In REQ with irq_vec=3, write MASK=0 before any ack -> irq_req falls the next cycle and state returns to IDLE. Repeat with ack in the same cycle as the MASK write -> SERVICE entered, CUR=0x8000_0003.
- Edge src[1] rises in the same cycle as a W1C write of PEND=0x2 -> PEND[1] remains 1. Write to address BASE+0x10 -> no register changes.
- Assert reset low in REQ state -> irq_req=0 immediately (async). Release reset -> no request until a new source event occurs.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM
// state encoding and the fixed-priority encoder used to pick a winner.
package irq_ctrl_pkg;

    localparam logic [1:0] OFF_PEND = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_EDGE = 2'd2;
    localparam logic [1:0] OFF_CUR  = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line, plus a
// rising-edge detector on the synchronised value.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic src_i,
    output logic s2,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = src_i;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign s2   = s2_q;
    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: latches synchronised sources, masks them,
// and hands the highest-priority one to CP0 through a req/ack/eret cycle.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          NSRC      = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            we,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq_req,
    output logic [2:0]      irq_vec,
    input  logic            irq_ack,
    input  logic            eret
);

    logic [NSRC-1:0] s2, rise;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] edge_q, edge_d;
    logic [1:0]      state_q, state_d;
    logic            req_q, req_d;
    logic [2:0]      vec_q, vec_d;
    logic            cur_v_q, cur_v_d;
    logic [2:0]      cur_idx_q, cur_idx_d;

    logic            hit;
    logic [1:0]      off;
    logic            wr_pend, wr_mask, wr_edge;
    logic [NSRC-1:0] w1c, ack_clr;
    logic [7:0]      en8, ack_clr8;
    logic [2:0]      winner;
    logic            ack_take;
    logic            unused_bits;

    for (genvar i = 0; i < NSRC; i++) begin : g_sync
        irq_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .src_i (src[i]),
            .s2    (s2[i]),
            .rise  (rise[i])
        );
    end

    assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign off     = addr[3:2];
    assign wr_pend = we && hit && (off == OFF_PEND);
    assign wr_mask = we && hit && (off == OFF_MASK);
    assign wr_edge = we && hit && (off == OFF_EDGE);

    assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};

    always_comb begin
        en8           = '0;
        en8[NSRC-1:0] = pend_q & mask_q;
    end

    assign winner = prio_enc(en8);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        vec_d     = vec_q;
        cur_v_d   = cur_v_q;
        cur_idx_d = cur_idx_q;
        ack_take  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|en8) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    vec_d   = winner;
                end
            end
            ST_REQ: begin
                // Ack beats withdrawal; the vector never moves while requesting.
                if (irq_ack) begin
                    state_d   = ST_SERVICE;
                    req_d     = 1'b0;
                    cur_v_d   = 1'b1;
                    cur_idx_d = vec_q;
                    ack_take  = 1'b1;
                end else if (!en8[vec_q]) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    state_d = ST_IDLE;
                    cur_v_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        ack_clr8 = ack_take ? (8'b1 << vec_q) : 8'b0;
        ack_clr  = ack_clr8[NSRC-1:0];
        w1c      = wr_pend ? wdata[NSRC-1:0] : '0;
        // Edge sources: a new rise overrides any clear in the same cycle.
        pend_d   = (edge_q & (rise | (pend_q & ~w1c & ~ack_clr))) | (~edge_q & s2);
        mask_d   = wr_mask ? wdata[NSRC-1:0] : mask_q;
        edge_d   = wr_edge ? wdata[NSRC-1:0] : edge_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q    <= '0;
            mask_q    <= '0;
            edge_q    <= '0;
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            vec_q     <= '0;
            cur_v_q   <= 1'b0;
            cur_idx_q <= '0;
        end else begin
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            state_q   <= state_d;
            req_q     <= req_d;
            vec_q     <= vec_d;
            cur_v_q   <= cur_v_d;
            cur_idx_q <= cur_idx_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_PEND: rdata[NSRC-1:0] = pend_q;
                OFF_MASK: rdata[NSRC-1:0] = mask_q;
                OFF_EDGE: rdata[NSRC-1:0] = edge_q;
                default: begin
                    rdata[31]  = cur_v_q;
                    rdata[2:0] = cur_idx_q;
                end
            endcase
        end
    end

    assign irq_req = req_q;
    assign irq_vec = vec_q;

endmodule
